// File: rtl/sorted_vector_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sorted_vector_streamer                                            |
// | Brief  : Absorbs a one-cycle sorted vector into a 2-slot ping-pong buffer  |
// |          and streams its elements one per valid/ready handshake.           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sorted_vector_streamer #(
    parameter int LOG_INPUT  = 4,
    parameter int DATA_WIDTH = 8,
    parameter bit REVERSE    = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  x_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  x,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic                                  m_last,
    output logic [LOG_INPUT-1:0]                  m_index,
    output logic                                  overflow,
    input  logic                                  ovf_clr,
    output logic                                  busy
);

    localparam int                   c_n        = 2**LOG_INPUT;
    localparam logic [LOG_INPUT-1:0] c_last_idx = {LOG_INPUT{1'b1}};

    logic [DATA_WIDTH*c_n-1:0] r_slot0;
    logic [DATA_WIDTH*c_n-1:0] r_slot1;
    logic                      r_wr_sel;
    logic                      r_rd_sel;
    logic [1:0]                r_count;
    logic [LOG_INPUT-1:0]      r_idx;
    logic                      r_overflow;

    logic                      w_fire;
    logic                      w_drain;
    logic                      w_accept;
    logic [1:0]                w_count_nxt;
    logic [DATA_WIDTH*c_n-1:0] w_rd_vec;
    logic [LOG_INPUT-1:0]      w_elem_sel;
    logic [DATA_WIDTH-1:0]     w_elems [c_n];

    assign m_valid  = (r_count != 2'd0);
    assign w_fire   = m_valid & m_ready;
    assign w_drain  = w_fire & (r_idx == c_last_idx);
    // A full buffer can still take a vector if a slot frees on this very edge.
    assign w_accept = x_valid & ((r_count != 2'd2) | w_drain);

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_drain) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_drain && !w_accept) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 2'd0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_drain) begin
                r_idx    <= '0;
                r_rd_sel <= ~r_rd_sel;
            end else if (w_fire) begin
                r_idx <= r_idx + 1'b1;
            end
            if (x_valid && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Slot payload needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_accept && !r_wr_sel) begin
            r_slot0 <= x;
        end
        if (w_accept && r_wr_sel) begin
            r_slot1 <= x;
        end
    end

    assign w_rd_vec = r_rd_sel ? r_slot1 : r_slot0;

    generate
        for (genvar k = 0; k < c_n; k++) begin : g_split
            assign w_elems[k] = w_rd_vec[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (REVERSE) begin : g_rev
            assign w_elem_sel = c_last_idx - r_idx;
        end else begin : g_fwd
            assign w_elem_sel = r_idx;
        end
    endgenerate

    assign m_data   = m_valid ? w_elems[w_elem_sel] : '0;
    assign m_index  = r_idx;
    assign m_last   = m_valid & (r_idx == c_last_idx);
    assign overflow = r_overflow;
    assign busy     = m_valid;

endmodule
`default_nettype wire

// File: tb/tb_sorted_vector_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sorted_vector_streamer                                         |
// | Brief  : Scenario bench for sorted_vector_streamer, forward and reversed   |
// |          instances checked against a queue-based reference model.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sorted_vector_streamer;

    localparam int c_log = 2;
    localparam int c_dw  = 8;
    localparam int c_n   = 4;

    logic        clk;
    logic        rst;
    logic        x_valid;
    logic [31:0] x;
    logic        m_ready;
    logic        ovf_clr;

    logic        m_valid,   r_m_valid;
    logic [7:0]  m_data,    r_m_data;
    logic        m_last,    r_m_last;
    logic [1:0]  m_index,   r_m_index;
    logic        overflow,  r_overflow;
    logic        busy,      r_busy;

    sorted_vector_streamer #(.LOG_INPUT(c_log), .DATA_WIDTH(c_dw), .REVERSE(1'b0)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_index(m_index), .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
    );

    sorted_vector_streamer #(.LOG_INPUT(c_log), .DATA_WIDTH(c_dw), .REVERSE(1'b1)) dut_r (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
        .m_valid(r_m_valid), .m_ready(m_ready), .m_data(r_m_data), .m_last(r_m_last),
        .m_index(r_m_index), .overflow(r_overflow), .ovf_clr(ovf_clr), .busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of whole vectors plus emission position.
    logic [31:0] vecs [$];
    int          pos;
    bit          ovf;
    bit          ev, el, eo;
    logic [7:0]  ed, erd;
    logic [1:0]  ei;

    task automatic model_reset();
        vecs.delete();
        pos = 0;
        ovf = 1'b0;
    endtask

    task automatic model_edge(input bit xv, input logic [31:0] xd, input bit rdy, input bit clr);
        bit valid, fire, drain, acc;
        valid = (vecs.size() != 0);
        fire  = valid && rdy;
        drain = fire && (pos == c_n - 1);
        acc   = xv && ((vecs.size() < 2) || drain);
        if (drain) begin
            void'(vecs.pop_front());
            pos = 0;
        end else if (fire) begin
            pos++;
        end
        if (acc) vecs.push_back(xd);
        if (xv && !acc) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
    endtask

    task automatic model_out();
        logic [31:0] v;
        ev  = (vecs.size() != 0);
        ei  = 2'(pos);
        el  = ev && (pos == c_n - 1);
        eo  = ovf;
        ed  = 8'h00;
        erd = 8'h00;
        if (ev) begin
            v   = vecs[0];
            ed  = v[8*pos +: 8];
            erd = v[8*(c_n-1-pos) +: 8];
        end
    endtask

    task automatic cycle(input bit xv, input logic [31:0] xd, input bit rdy, input bit clr);
        x_valid = xv;
        x       = xd;
        m_ready = rdy;
        ovf_clr = clr;
        @(posedge clk);
        model_edge(xv, xd, rdy, clr);
        #1;
        x_valid = 1'b0;
        ovf_clr = 1'b0;
        model_out();
    endtask

    task automatic test_reset();
        rst = 1'b0; x_valid = 1'b0; x = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_index !== 2'd0 || m_data !== 8'h00 ||
            busy !== 1'b0 || overflow !== 1'b0 || r_m_valid !== 1'b0 || r_m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: got v%b l%b i%0d d%h b%b o%b rv%b rd%h, required all zero",
                     m_valid, m_last, m_index, m_data, busy, overflow, r_m_valid, r_m_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] fwd [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00};
        cycle(1'b1, 32'h40302010, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed || m_data !== fwd[c] ||
                r_m_data !== erd || r_m_last !== el || busy !== ev || overflow !== eo) begin
                errors++;
                $display("FAIL basic c%0d: got v%b i%0d l%b d%h rd%h b%b o%b, required v%b i%0d l%b d%h rd%h o%b",
                         c, m_valid, m_index, m_last, m_data, r_m_data, busy, overflow, ev, ei, el, ed, erd, eo);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 32'h40302010, 1'b0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed ||
                r_m_data !== erd || busy !== ev || overflow !== eo) begin
                errors++;
                $display("FAIL backpressure c%0d: got v%b i%0d l%b d%h rd%h, required v%b i%0d l%b d%h rd%h",
                         c, m_valid, m_index, m_last, m_data, r_m_data, ev, ei, el, ed, erd);
            end
            cycle(1'b0, '0, (c >= 5), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 32'h04030201, 1'b1, 1'b0);
        cycle(1'b1, 32'h44332211, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed ||
                r_m_data !== erd || overflow !== 1'b0 || overflow !== eo) begin
                errors++;
                $display("FAIL back_to_back c%0d: got v%b i%0d l%b d%h rd%h o%b, required v%b i%0d l%b d%h rd%h o%b",
                         c, m_valid, m_index, m_last, m_data, r_m_data, overflow, ev, ei, el, ed, erd, eo);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 32'h04030201, 1'b0, 1'b0);
        cycle(1'b1, 32'h44332211, 1'b0, 1'b0);
        cycle(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || r_overflow !== 1'b1 || eo !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got o%b ro%b b%b, required o1 b1", overflow, r_overflow, busy);
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, '0, 1'b1, (c == 9));
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed ||
                r_m_data !== erd || overflow !== eo) begin
                errors++;
                $display("FAIL overflow_drain c%0d: got v%b i%0d l%b d%h rd%h o%b, required v%b i%0d l%b d%h rd%h o%b",
                         c, m_valid, m_index, m_last, m_data, r_m_data, overflow, ev, ei, el, ed, erd, eo);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got o%b, required o0", overflow);
        end
        // Third vector lands on the same edge as the first vector's last fire.
        cycle(1'b1, 32'h04030201, 1'b0, 1'b0);
        cycle(1'b1, 32'h44332211, 1'b0, 1'b0);
        for (int c = 0; c < 13; c++) begin
            cycle((c == 3), 32'hDDCCBBAA, 1'b1, 1'b0);
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed ||
                r_m_data !== erd || overflow !== 1'b0 || overflow !== eo) begin
                errors++;
                $display("FAIL overflow_coincident c%0d: got v%b i%0d l%b d%h rd%h o%b, required v%b i%0d l%b d%h rd%h o0",
                         c, m_valid, m_index, m_last, m_data, r_m_data, overflow, ev, ei, el, ed, erd);
            end
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 32'h40302010, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0 || m_index !== 2'd0 ||
            m_last !== 1'b0 || r_m_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got v%b d%h b%b i%0d l%b rd%h, required all zero",
                     m_valid, m_data, busy, m_index, m_last, r_m_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 32'h88776655, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed || r_m_data !== erd) begin
                errors++;
                $display("FAIL after_reset c%0d: got v%b i%0d l%b d%h rd%h, required v%b i%0d l%b d%h rd%h",
                         c, m_valid, m_index, m_last, m_data, r_m_data, ev, ei, el, ed, erd);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 99) < 35), $urandom, ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 5));
            checks++;
            if (m_valid !== ev || m_index !== ei || m_last !== el || m_data !== ed || r_m_data !== erd ||
                r_m_last !== el || busy !== ev || overflow !== eo || r_overflow !== eo) begin
                errors++;
                $display("FAIL random c%0d: got v%b i%0d l%b d%h rd%h b%b o%b, required v%b i%0d l%b d%h rd%h o%b",
                         c, m_valid, m_index, m_last, m_data, r_m_data, busy, overflow, ev, ei, el, ed, erd, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
